// File: rtl/bit_index_scanner.sv
// Accepts a WIDTH-bit request vector and emits the index of each set bit, one beat at a time.
// Latency: first beat one cycle after acceptance; K set bits take K beats (one beat for an all-zero vector).
// Backpressure: out_ready low holds the current beat stable; in_ready is low for the whole scan.
// Build option: define BIT_SCAN_MSB_FIRST_EN to emit indices highest-first instead of lowest-first.
module bit_index_scanner #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH)-1:0]   out_idx,
  output logic                       out_last,
  output logic                       out_zero,
  output logic                       busy
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_nxt;
  logic             zero_flag;
  logic             zero_flag_nxt;
  logic [IDX_W-1:0] scan_idx;
  logic             single_bit;
  logic             in_fire;
  logic             out_fire;

  // Pick the bit to emit next; later loop iterations take priority, so the loop direction sets the order.
  always_comb begin
    scan_idx = '0;
`ifdef BIT_SCAN_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pending[i]) scan_idx = IDX_W'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) scan_idx = IDX_W'(i);
    end
`endif
  end

  // At most one bit left means the current beat is the final one (also true for an all-zero vector).
  assign single_bit = ((pending & (pending - WIDTH'(1))) == '0);

  // Handshake and outputs depend only on registered state; in_ready is additionally masked by reset.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == SCAN);
  assign busy      = (state == SCAN);
  assign out_idx   = out_valid ? scan_idx : '0;
  assign out_last  = out_valid && single_bit;
  assign out_zero  = out_valid && zero_flag;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Next-state: load a vector in IDLE, retire one set bit per accepted beat in SCAN.
  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    zero_flag_nxt = zero_flag;
    case (state)
      IDLE: begin
        if (in_fire) begin
          pending_nxt   = in_vec;
          zero_flag_nxt = (in_vec == '0);
          state_nxt     = SCAN;
        end
      end
      SCAN: begin
        if (out_fire) begin
          pending_nxt = pending & ~(WIDTH'(1) << scan_idx);
          if (single_bit) begin
            state_nxt     = IDLE;
            zero_flag_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-scan drops the pending vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      zero_flag <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      zero_flag <= zero_flag_nxt;
    end
  end

endmodule

// File: tb/tb_bit_index_scanner.sv
module tb_bit_index_scanner;

  localparam int WIDTH = 8;
  localparam int IDX_W = $clog2(WIDTH);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;
  logic             busy;

  int vectors;
  int miscompares;
  int exp_q[$];

  bit_index_scanner #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of set-bit positions in emission order; a zero vector yields a single index 0.
  task automatic build_exp(input logic [WIDTH-1:0] vec);
    exp_q.delete();
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) exp_q.push_back(i);
    end
`ifdef BIT_SCAN_MSB_FIRST_EN
    exp_q.reverse();
`endif
    if (exp_q.size() == 0) exp_q.push_back(0);
  endtask

  // Send one vector from IDLE and check every beat (including stalled cycles) against the model.
  task automatic run_vector(input logic [WIDTH-1:0] vec, input bit rnd_bp, input string tag);
    int   cyc;
    int   nbeats;
    int   ei;
    logic el;
    logic ez;
    logic rdy;
    build_exp(vec);
    nbeats = exp_q.size();
    ez = (vec == '0);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready_before: got %b expected 1", tag, in_ready);
    end
    in_valid = 1'b1;
    in_vec   = vec;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec   = WIDTH'($urandom);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      ei = exp_q[0];
      el = (exp_q.size() == 1);
      vectors++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s handshake: got valid=%b busy=%b in_ready=%b expected 1 1 0", tag, out_valid, busy, in_ready);
      end
      vectors++;
      if (out_idx !== IDX_W'(ei) || out_last !== el || out_zero !== ez) begin
        miscompares++;
        $display("FAIL %s beat: got idx=%0d last=%b zero=%b expected idx=%0d last=%b zero=%b",
                 tag, out_idx, out_last, out_zero, ei, el, ez);
      end
      rdy = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      @(posedge clk); #1;
      cyc++;
      if (rdy) void'(exp_q.pop_front());
    end
    out_ready = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s timeout: got %0d beats left expected 0", tag, exp_q.size());
    end
    if (!rnd_bp) begin
      vectors++;
      if (cyc != nbeats) begin
        miscompares++;
        $display("FAIL %s scan_cycles: got %0d expected %0d", tag, cyc, nbeats);
      end
    end
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s after_scan: got valid=%b busy=%b in_ready=%b expected 0 0 1", tag, out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 ||
          out_idx !== '0 || out_last !== 1'b0 || out_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: got valid=%b rdy=%b busy=%b idx=%0d last=%b zero=%b expected all 0",
                 out_valid, in_ready, busy, out_idx, out_last, out_zero);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_one_hot();
    for (int i = 0; i < WIDTH; i++) begin
      run_vector(WIDTH'(1) << i, 1'b0, "one_hot");
    end
  endtask

  task automatic test_multi_bit();
    run_vector(8'b10100110, 1'b0, "multi_bit");
  endtask

  task automatic test_zero();
    run_vector(8'h00, 1'b0, "zero_vec");
  endtask

  task automatic test_backpressure();
    int first;
    build_exp(8'b00010010);
    first = exp_q[0];
    in_valid = 1'b1; in_vec = 8'b00010010; out_ready = 1'b0;
    @(posedge clk); #1;
    in_vec = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== IDX_W'(first) ||
          out_last !== 1'b0 || out_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold: got valid=%b rdy=%b idx=%0d last=%b zero=%b expected 1 0 %0d 0 0",
                 out_valid, in_ready, out_idx, out_last, out_zero, first);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== IDX_W'(exp_q[b]) || out_last !== (b == 1) || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_release: got valid=%b idx=%0d last=%b rdy=%b expected 1 %0d %b 0",
                 out_valid, out_idx, out_last, in_ready, exp_q[b], (b == 1));
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    // in_valid is still high with 8'hFF; it must be taken only now, from IDLE.
    run_vector(8'hFF, 1'b0, "bp_after");
  endtask

  task automatic test_reset_mid_scan();
    build_exp(8'hFF);
    in_valid = 1'b1; in_vec = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== IDX_W'(exp_q[b]) || out_last !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_rst_beat: got valid=%b idx=%0d last=%b expected 1 %0d 0",
                 out_valid, out_idx, out_last, exp_q[b]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst_abort: got valid=%b busy=%b in_ready=%b expected 0 0 0", out_valid, busy, in_ready);
    end
    rst = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    run_vector(8'b00001000, 1'b0, "mid_rst_new");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] v;
    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      run_vector(v, 1'b1, "random");
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_one_hot();
    test_multi_bit();
    test_zero();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
